// File: rtl/booth_mult_ctrl.sv
// Sequencing controller for a radix-2 Booth multiplier datapath.
// Optional macro BOOTH_CTRL_FUSED_STEP_EN merges add/sub and shift into one EVAL cycle.
module booth_mult_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] q_lsb,
  output logic       load_operands,
  output logic       add_multiplicand,
  output logic       subtract_multiplicand,
  output logic       shift,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    DONE  = 3'd3
`ifndef BOOTH_CTRL_FUSED_STEP_EN
    ,SHIFT = 3'd4
`endif
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  // State and iteration counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and Moore command decode; everything is forced low while in reset
  always_comb begin
    state_nx              = state;
    cnt_nx                = cnt;
    req_ready             = 1'b0;
    load_operands         = 1'b0;
    add_multiplicand      = 1'b0;
    subtract_multiplicand = 1'b0;
    shift                 = 1'b0;
    busy                  = 1'b0;
    done                  = 1'b0;

    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx = LOAD;
          cnt_nx   = '0;
        end
      end
      LOAD: begin
        busy          = 1'b1;
        load_operands = 1'b1;
        state_nx      = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        unique case (q_lsb)
          2'b10:   subtract_multiplicand = 1'b1;
          2'b01:   add_multiplicand      = 1'b1;
          default: ;
        endcase
`ifdef BOOTH_CTRL_FUSED_STEP_EN
        shift = 1'b1;
        if (cnt == LAST_ITER) begin
          state_nx = DONE;
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
          state_nx = EVAL;
        end
`else
        state_nx = SHIFT;
`endif
      end
`ifndef BOOTH_CTRL_FUSED_STEP_EN
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt == LAST_ITER) begin
          state_nx = DONE;
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
          state_nx = EVAL;
        end
      end
`endif
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (rst) begin
      req_ready             = 1'b0;
      load_operands         = 1'b0;
      add_multiplicand      = 1'b0;
      subtract_multiplicand = 1'b0;
      shift                 = 1'b0;
      busy                  = 1'b0;
      done                  = 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl driving a behavioural Booth datapath model.
module tb_booth_mult_ctrl;

  localparam int W = 8;
`ifdef BOOTH_CTRL_FUSED_STEP_EN
  localparam int LAT = W;
`else
  localparam int LAT = 2 * W;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] q_lsb;
  logic       load_operands, add_multiplicand, subtract_multiplicand, shift, busy, done;

  always #5 clk = ~clk;

  booth_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .q_lsb(q_lsb),
    .load_operands(load_operands), .add_multiplicand(add_multiplicand),
    .subtract_multiplicand(subtract_multiplicand), .shift(shift), .busy(busy), .done(done)
  );

  // Behavioural datapath: add/sub applied before the arithmetic shift on the same edge
  logic [W-1:0] a_in, b_in, acc, q, acc_t;
  logic         qm1;
  assign q_lsb = {q[0], qm1};
  always_comb begin
    acc_t = acc;
    if (add_multiplicand)      acc_t = acc + a_in;
    if (subtract_multiplicand) acc_t = acc - a_in;
  end
  always @(posedge clk) begin
    if (load_operands) begin
      acc <= '0; q <= b_in; qm1 <= 1'b0;
    end else if (shift) begin
      {acc, q, qm1} <= {acc_t[W-1], acc_t, q};
    end else begin
      acc <= acc_t;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] prod;
    logic [15:0] ops;
    int          done_cyc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Monitor: per-iteration op trace (0 none, 1 add, 2 sub) and all comparisons
  logic [15:0] trace;
  int          idx;
  logic [1:0]  pend;
  logic        both;
  logic        rst_d = 1'b0;
  logic        end_chk = 1'b0;
  logic        fin = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst)
      check("rst_outputs", int'({req_ready, load_operands, add_multiplicand,
                                 subtract_multiplicand, shift, busy, done}), 0);
    else if (rst_d)
      check("post_rst_ready", int'({req_ready, busy}), 2);
    rst_d = rst;
    if (add_multiplicand && subtract_multiplicand) both = 1'b1;
    if (load_operands) begin
      trace = '0; idx = 0; pend = 2'd0; both = 1'b0;
    end
    if (add_multiplicand)      pend = 2'd1;
    if (subtract_multiplicand) pend = 2'd2;
    if (shift) begin
      if (idx < W) trace[2*idx +: 2] = pend;
      idx++;
      pend = 2'd0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("product", int'({acc, q}), int'(e.prod));
        check("op_trace", int'(trace), int'(e.ops));
        check("iterations", idx, W);
        check("done_cycle", cyc, e.done_cyc);
        check("add_sub_exclusive", int'(both), 0);
      end
    end
    if (end_chk && !fin) begin
      check("drain", sb.size(), 0);
      fin = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    int k = 0;
    while (!req_ready) begin
      tick();
      k++;
      if (k > 200) begin
        $display("FAIL wait_ready: req_ready never rose at cycle %0d", cyc);
        $fatal(1, "timeout");
      end
    end
    n = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 300) begin
      tick();
      k++;
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] prod, input logic [15:0] ops);
    int n;
    tick();
    a_in = a; b_in = b; req_valid = 1'b1;
    wait_ready(n);
    sb.push_back('{prod: prod, ops: ops, done_cyc: n + 2 + LAT});
    tick();
    req_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b1; a_in = '0; b_in = '0;
    repeat (2) tick();
    rst = 1'b0; req_valid = 1'b0;
    repeat (2) tick();

    run(8'd3,   8'h05, 16'h000F, 16'h0066);
    run(8'd7,   8'hFF, 16'hFFF9, 16'h0002);
    run(8'h7F,  8'h80, 16'hC080, 16'h8000);

    // Abort A=3,B=5 during the fifth EVAL; no expectation is queued
    tick();
    a_in = 8'd3; b_in = 8'h05; req_valid = 1'b1;
    wait_ready(n);
    tick();
    req_valid = 1'b0;
`ifdef BOOTH_CTRL_FUSED_STEP_EN
    repeat (5) @(posedge clk);
`else
    repeat (9) @(posedge clk);
`endif
    #1 rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    run(8'd2, 8'd2, 16'h0004, 16'h0018);

    // Back-to-back with req_valid held high
    tick();
    a_in = 8'd3; b_in = 8'h05; req_valid = 1'b1;
    wait_ready(n);
    sb.push_back('{prod: 16'h000F, ops: 16'h0066, done_cyc: n + 2 + LAT});
    sb.push_back('{prod: 16'h000F, ops: 16'h0066, done_cyc: n + 3 + LAT + 2 + LAT});
    tick();
    wait_ready(n);
    tick();
    req_valid = 1'b0;
    wait_idle();

    repeat (2) tick();
    end_chk = 1'b1;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mult_ctrl.md
# booth_mult_ctrl

Sequencing controller for the radix-2 Booth multiplier datapath. Accepts a multiply request over a valid/ready handshake, issues one load, then per-bit add/subtract and arithmetic-shift commands based on the datapath's two low Booth bits, and pulses `done` when the product is final. Sits between the requester (ALU/top-level FSM) and the multiplier datapath, which it fully owns while busy.

## Interface
- `WIDTH`, default 8: operand width; the controller issues exactly WIDTH Booth iterations.
- `CNT_W`, default $clog2(WIDTH): iteration counter width (derived, not overridden).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: requester has operands ready on the datapath inputs.
- `req_ready` out 1: controller idle and can accept; transfer when `req_valid & req_ready`.
- `q_lsb` in 2: `{Q[0], Q[-1]}` from datapath register bits [1:0].
- `load_operands` out 1: datapath loads B into Q, clears accumulator and Q[-1].
- `add_multiplicand` out 1: accumulator += A this edge.
- `subtract_multiplicand` out 1: accumulator -= A this edge.
- `shift` out 1: arithmetic right shift of {acc, Q, Q[-1]} this edge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; product valid on datapath outputs.

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, DONE.
- IDLE: `req_ready`=1. Handshake → LOAD; counter cleared.
- LOAD: `load_operands`=1 for exactly one cycle → EVAL.
- EVAL: decode `q_lsb`: 2'b10 → `subtract_multiplicand`=1; 2'b01 → `add_multiplicand`=1; 2'b00/2'b11 → neither. → SHIFT.
- SHIFT: `shift`=1. If counter == WIDTH-1 → DONE, else counter+1 → EVAL.
- DONE: `done`=1 one cycle → IDLE.
- `add_multiplicand` and `subtract_multiplicand` never both high; command outputs are zero outside their states.
- All outputs Moore-decoded from state; `req_ready` = (state==IDLE) & ~rst.
- Counter wrap: never wraps; terminates at WIDTH-1.

## Timing
- Reset: with `rst` high at an edge, state→IDLE, counter→0. While `rst` high: `req_ready`, `load_operands`, `add_multiplicand`, `subtract_multiplicand`, `shift`, `busy`, `done` all 0.
- Handshake at edge N: LOAD during cycle N+1, first EVAL N+2.
- Default: 2 cycles per bit; `done` high during cycle N+2+2·WIDTH (N+18 for WIDTH=8). `req_ready` high again at N+3+2·WIDTH.
- `q_lsb` sampled in EVAL reflects the previous SHIFT edge (or the LOAD edge for iteration 0).
- `req_valid` while not IDLE: ignored, no queueing; held-high `req_valid` is accepted on the first IDLE cycle after DONE.
- Reset mid-operation (any state): IDLE on the next edge, no `done` pulse, no further commands.

## Configuration
- `BOOTH_CTRL_FUSED_STEP_EN`: when defined, the SHIFT state is removed; EVAL asserts the add/subtract decision and `shift` in the same cycle, counts, and goes to DONE after the WIDTH-th EVAL. Latency becomes N+2+WIDTH (`done` at N+10 for WIDTH=8). Datapath must apply add/sub before shift within one edge.
- Undefined: separate EVAL and SHIFT states, 2 cycles per bit, as above.

## Test plan
- Reset: hold `rst` 2 cycles with `req_valid`=1 → all outputs 0, no handshake; after release `req_ready`=1 next cycle.
- A=3, B=0x05 (behavioural datapath model) → command sequence sub, add, sub, add, none×4, each followed by `shift`; `done` at N+18; product 0x000F.
- A=7, B=0xFF → sub on iteration 0, none on 1–7; product 0xFFF9 (−7).
- A=0x7F, B=0x80 → none on iterations 0–6, sub on 7; product 0xC080 (−16256).
- Assert `rst` in 5th EVAL of A=3,B=5 → IDLE next edge, no `done`; next request A=2,B=2 completes with product 0x0004.
- `req_valid` held high across two requests → second accepted in the cycle after `done` (N+19); with `BOOTH_CTRL_FUSED_STEP_EN`, first `done` at N+10, second accepted at N+11.
